// File: rtl/garbage_manager_if.sv
// rtl/garbage_manager_if.sv - lock/garbage bus between clear detector, garbage manager and its consumers
//
// Purpose: groups every non-clock signal of garbage_manager into one bundle.
// Ports (signals):
//   game_start            sync clear, same effect as reset
//   piece_locked          one-cycle lock pulse
//   lines_clr_cnt[2:0]    rows cleared by the lock (0..4)
//   tspin                 lock was a T-spin
//   garbage_in_valid      opponent sent garbage (pulse)
//   garbage_in_lines[3:0] rows received (1..15)
//   attack_valid          attack_lines valid (pulse)
//   attack_lines[3:0]     rows sent after cancellation
//   lines_sent_total[9:0] cumulative rows sent
//   combo_cnt[4:0]        consecutive clearing locks
//   b2b_active            last clearing lock was difficult
//   garbage_pending[4:0]  incoming rows awaiting insertion
//   garbage_insert_valid  insertion request (pulse)
//   garbage_insert_lines[3:0] rows to insert
// master = upstream/downstream side, slave = garbage_manager.
interface garbage_manager_if;
  logic       game_start;
  logic       piece_locked;
  logic [2:0] lines_clr_cnt;
  logic       tspin;
  logic       garbage_in_valid;
  logic [3:0] garbage_in_lines;
  logic       attack_valid;
  logic [3:0] attack_lines;
  logic [9:0] lines_sent_total;
  logic [4:0] combo_cnt;
  logic       b2b_active;
  logic [4:0] garbage_pending;
  logic       garbage_insert_valid;
  logic [3:0] garbage_insert_lines;

  modport master (
    output game_start, piece_locked, lines_clr_cnt, tspin,
           garbage_in_valid, garbage_in_lines,
    input  attack_valid, attack_lines, lines_sent_total, combo_cnt,
           b2b_active, garbage_pending, garbage_insert_valid,
           garbage_insert_lines
  );

  modport slave (
    input  game_start, piece_locked, lines_clr_cnt, tspin,
           garbage_in_valid, garbage_in_lines,
    output attack_valid, attack_lines, lines_sent_total, combo_cnt,
           b2b_active, garbage_pending, garbage_insert_valid,
           garbage_insert_lines
  );
endinterface

// File: rtl/garbage_manager.sv
// rtl/garbage_manager.sv - attack computation, garbage cancellation and insertion bookkeeping
//
// Purpose: on each piece lock computes attack = base + b2b + combo, cancels
// pending incoming garbage first, sends the remainder, and releases pending
// garbage on non-clearing locks. Accumulates garbage received from the opponent.
// Ports:
//   clk    system clock
//   rst_l  synchronous reset, active-high
//   bus    garbage_manager_if.slave (all lock, garbage and status signals)
// All outputs are registered; latency is one cycle.
module garbage_manager #(
  parameter int MAX_PENDING = 20,
  parameter int MAX_INSERT  = 8
) (
  input  logic                clk,
  input  logic                rst_l,
  garbage_manager_if.slave    bus
);

  localparam logic [4:0] MAX_PEND5 = 5'(MAX_PENDING);
  localparam logic [4:0] MAX_INS5  = 5'(MAX_INSERT);
  localparam logic [3:0] MAX_INS4  = 4'(MAX_INSERT);

  logic [3:0] attack_lines_q;
  logic       attack_valid_q;
  logic [9:0] total_q;
  logic [4:0] combo_q;
  logic       b2b_q;
  logic [4:0] pending_q;
  logic       insert_valid_q;
  logic [3:0] insert_lines_q;

  logic [2:0] lines;
  logic       lock;
  logic       clearing;
  logic       tspin_eff;
  logic       difficult;
  logic [3:0] base;
  logic [2:0] combo_bonus;
  logic [3:0] raw;
  logic [3:0] cancel;
  logic [3:0] attack;
  logic [3:0] ins;
  logic       insert_fire;
  logic [4:0] pend_after_lock;
  logic [5:0] pend_sum;
  logic [4:0] pend_next;
  logic [10:0] total_sum;
  logic [9:0] total_next;
  logic [4:0] combo_next;
  logic       b2b_next;

  assign lines    = bus.lines_clr_cnt;
  assign lock     = bus.piece_locked;
  assign clearing = (lines != 3'd0);

  // A T-spin with L = 4 is not a T-spin clear; it scores as a plain tetris.
  assign tspin_eff = bus.tspin && (lines >= 3'd1) && (lines <= 3'd3);
  assign difficult = (lines == 3'd4) || tspin_eff;

  always_comb begin
    base = 4'd0;
    if (tspin_eff) begin
      base = {lines, 1'b0};
    end else begin
      case (lines)
        3'd2:    base = 4'd1;
        3'd3:    base = 4'd2;
        3'd4:    base = 4'd4;
        default: base = 4'd0;
      endcase
    end
  end

  // Combo bonus is indexed by the streak length before this lock.
  always_comb begin
    combo_bonus = 3'd0;
    if (clearing) begin
      case (combo_q)
        5'd0:             combo_bonus = 3'd0;
        5'd1, 5'd2:       combo_bonus = 3'd1;
        5'd3, 5'd4:       combo_bonus = 3'd2;
        5'd5, 5'd6:       combo_bonus = 3'd3;
        5'd7, 5'd8, 5'd9: combo_bonus = 3'd4;
        default:          combo_bonus = 3'd5;
      endcase
    end
  end

  assign raw = base + {3'b000, difficult && b2b_q} + {1'b0, combo_bonus};

  // When pending <= raw (<= 12) pending fits in 4 bits, so the slice is exact.
  assign cancel = ({1'b0, raw} < pending_q) ? raw : pending_q[3:0];
  assign attack = raw - cancel;

  // Same reasoning: below MAX_INSERT the pending count fits in 4 bits.
  assign ins         = (pending_q < MAX_INS5) ? pending_q[3:0] : MAX_INS4;
  assign insert_fire = lock && !clearing && (pending_q != 5'd0);

  // Lock effects apply first; incoming rows are added afterwards so they are
  // never cancelled or inserted in the cycle they arrive.
  always_comb begin
    pend_after_lock = pending_q;
    if (lock && clearing) begin
      pend_after_lock = pending_q - {1'b0, cancel};
    end else if (insert_fire) begin
      pend_after_lock = pending_q - {1'b0, ins};
    end
  end

  assign pend_sum  = {1'b0, pend_after_lock}
                   + (bus.garbage_in_valid ? {2'b00, bus.garbage_in_lines} : 6'd0);
  assign pend_next = (pend_sum > {1'b0, MAX_PEND5}) ? MAX_PEND5 : pend_sum[4:0];

  assign total_sum  = {1'b0, total_q} + {7'd0, attack};
  assign total_next = total_sum[10] ? 10'd1023 : total_sum[9:0];

  assign combo_next = !clearing ? 5'd0 :
                      (combo_q == 5'd31) ? 5'd31 : combo_q + 5'd1;

  // L == 0 leaves the back-to-back chain untouched.
  assign b2b_next = difficult ? 1'b1 : (clearing ? 1'b0 : b2b_q);

  always_ff @(posedge clk) begin
    if (rst_l || bus.game_start) begin
      attack_valid_q <= 1'b0;
      attack_lines_q <= 4'd0;
      total_q        <= 10'd0;
      combo_q        <= 5'd0;
      b2b_q          <= 1'b0;
      pending_q      <= 5'd0;
      insert_valid_q <= 1'b0;
      insert_lines_q <= 4'd0;
    end else begin
      attack_valid_q <= lock && (raw != 4'd0);
      insert_valid_q <= insert_fire;
      pending_q      <= pend_next;
      if (lock) begin
        combo_q <= combo_next;
        b2b_q   <= b2b_next;
        if (raw != 4'd0) begin
          attack_lines_q <= attack;
          total_q        <= total_next;
        end
        if (insert_fire) begin
          insert_lines_q <= ins;
        end
      end
    end
  end

  assign bus.attack_valid         = attack_valid_q;
  assign bus.attack_lines         = attack_lines_q;
  assign bus.lines_sent_total     = total_q;
  assign bus.combo_cnt            = combo_q;
  assign bus.b2b_active           = b2b_q;
  assign bus.garbage_pending      = pending_q;
  assign bus.garbage_insert_valid = insert_valid_q;
  assign bus.garbage_insert_lines = insert_lines_q;

endmodule

// File: tb/tb_garbage_manager.sv
// tb/tb_garbage_manager.sv - directed self-checking bench for garbage_manager
module tb_garbage_manager;
  logic clk = 1'b0;
  logic rst_l;
  int   checks = 0;
  int   errors = 0;

  garbage_manager_if gif ();

  garbage_manager #(.MAX_PENDING(20), .MAX_INSERT(8)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (gif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of strobes, sample 1 time unit after the edge, drop strobes.
  task automatic step(input logic lk, input logic [2:0] l, input logic ts,
                      input logic gv, input logic [3:0] gl, input logic gs);
    gif.piece_locked     = lk;
    gif.lines_clr_cnt    = l;
    gif.tspin            = ts;
    gif.garbage_in_valid = gv;
    gif.garbage_in_lines = gl;
    gif.game_start       = gs;
    @(posedge clk);
    #1;
    gif.piece_locked     = 1'b0;
    gif.garbage_in_valid = 1'b0;
    gif.game_start       = 1'b0;
  endtask

  int ladder[12] = '{1, 2, 2, 3, 3, 4, 4, 5, 5, 5, 6, 6};
  int ladder_total;

  initial begin
    gif.piece_locked = 1'b0; gif.lines_clr_cnt = 3'd0; gif.tspin = 1'b0;
    gif.garbage_in_valid = 1'b0; gif.garbage_in_lines = 4'd0; gif.game_start = 1'b0;
    rst_l = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b0;
    chk("rst_attack_valid", gif.attack_valid, 0);
    chk("rst_total", gif.lines_sent_total, 0);
    chk("rst_combo", gif.combo_cnt, 0);
    chk("rst_b2b", gif.b2b_active, 0);
    chk("rst_pending", gif.garbage_pending, 0);
    chk("rst_insert_valid", gif.garbage_insert_valid, 0);

    // single, tetris, tetris
    step(1, 3'd1, 0, 0, 4'd0, 0);
    chk("single_no_attack", gif.attack_valid, 0);
    chk("single_combo", gif.combo_cnt, 1);
    step(1, 3'd4, 0, 0, 4'd0, 0);
    chk("tetris1_valid", gif.attack_valid, 1);
    chk("tetris1_lines", gif.attack_lines, 5);
    step(1, 3'd4, 0, 0, 4'd0, 0);
    chk("tetris2_valid", gif.attack_valid, 1);
    chk("tetris2_lines", gif.attack_lines, 6);
    chk("tetris2_b2b", gif.b2b_active, 1);
    chk("tetris2_combo", gif.combo_cnt, 3);
    chk("tetris2_total", gif.lines_sent_total, 11);
    step(1, 3'd0, 0, 0, 4'd0, 0);
    chk("break_combo", gif.combo_cnt, 0);
    chk("break_no_attack", gif.attack_valid, 0);
    chk("break_b2b_kept", gif.b2b_active, 1);

    // combo ladder of 12 doubles
    ladder_total = 11;
    for (int i = 0; i < 12; i++) begin
      step(1, 3'd2, 0, 0, 4'd0, 0);
      chk($sformatf("ladder%0d_valid", i), gif.attack_valid, 1);
      chk($sformatf("ladder%0d_lines", i), gif.attack_lines, ladder[i]);
      ladder_total += ladder[i];
    end
    chk("ladder_total", gif.lines_sent_total, ladder_total);
    chk("ladder_combo", gif.combo_cnt, 12);
    chk("ladder_b2b_cleared", gif.b2b_active, 0);
    step(1, 3'd0, 0, 0, 4'd0, 0);
    chk("ladder_end_combo", gif.combo_cnt, 0);
    chk("ladder_end_no_attack", gif.attack_valid, 0);
    chk("ladder_end_no_insert", gif.garbage_insert_valid, 0);

    // cancellation: tspin double raw 4, then triple raw 2+1 = 3
    step(0, 3'd0, 0, 1, 4'd7, 0);
    chk("recv7_pending", gif.garbage_pending, 7);
    step(1, 3'd2, 1, 0, 4'd0, 0);
    chk("tsd_valid", gif.attack_valid, 1);
    chk("tsd_lines", gif.attack_lines, 0);
    chk("tsd_pending", gif.garbage_pending, 3);
    step(1, 3'd3, 0, 0, 4'd0, 0);
    chk("triple_valid", gif.attack_valid, 1);
    chk("triple_lines", gif.attack_lines, 0);
    chk("triple_pending", gif.garbage_pending, 0);
    chk("cancel_total", gif.lines_sent_total, 57);

    // insertion with saturated pending
    step(0, 3'd0, 0, 1, 4'd15, 0);
    chk("recv15_pending", gif.garbage_pending, 15);
    step(0, 3'd0, 0, 1, 4'd15, 0);
    chk("recv_sat_pending", gif.garbage_pending, 20);
    step(1, 3'd0, 0, 0, 4'd0, 0);
    chk("ins1_valid", gif.garbage_insert_valid, 1);
    chk("ins1_lines", gif.garbage_insert_lines, 8);
    chk("ins1_pending", gif.garbage_pending, 12);
    step(1, 3'd0, 0, 0, 4'd0, 0);
    chk("ins2_lines", gif.garbage_insert_lines, 8);
    chk("ins2_pending", gif.garbage_pending, 4);
    step(1, 3'd0, 0, 0, 4'd0, 0);
    chk("ins3_valid", gif.garbage_insert_valid, 1);
    chk("ins3_lines", gif.garbage_insert_lines, 4);
    chk("ins3_pending", gif.garbage_pending, 0);
    step(0, 3'd0, 0, 0, 4'd0, 0);
    chk("ins_pulse_drop", gif.garbage_insert_valid, 0);
    step(1, 3'd0, 0, 0, 4'd0, 0);
    chk("ins_empty_none", gif.garbage_insert_valid, 0);

    // same-cycle lock and receive
    step(0, 3'd0, 0, 1, 4'd2, 0);
    chk("recv2_pending", gif.garbage_pending, 2);
    step(1, 3'd4, 0, 1, 4'd5, 0);
    chk("same_valid", gif.attack_valid, 1);
    chk("same_lines", gif.attack_lines, 2);
    chk("same_pending", gif.garbage_pending, 5);
    chk("same_total", gif.lines_sent_total, 59);
    chk("same_b2b", gif.b2b_active, 1);
    step(0, 3'd0, 0, 0, 4'd0, 0);
    chk("attack_pulse_drop", gif.attack_valid, 0);

    // game_start overrides a tetris lock
    step(1, 3'd4, 0, 1, 4'd3, 1);
    chk("gs_attack_valid", gif.attack_valid, 0);
    chk("gs_attack_lines", gif.attack_lines, 0);
    chk("gs_total", gif.lines_sent_total, 0);
    chk("gs_combo", gif.combo_cnt, 0);
    chk("gs_b2b", gif.b2b_active, 0);
    chk("gs_pending", gif.garbage_pending, 0);
    chk("gs_insert_lines", gif.garbage_insert_lines, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
